// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the TX block scheduler.
// Holds the FSM state enum, header bytes and block-size default.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_SEND,
    S_GAP
  } state_e;

  localparam int         NUM_BYTES_DEF = 8;
  localparam logic [7:0] HDR0_DEF      = 8'hA5;
  localparam logic [7:0] HDR1_DEF      = 8'h5A;

endpackage

// File: rtl/tx_block_scheduler_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: valid0_i/valid1_i requests, last_grant_i, gnt0_o/gnt1_o/gnt_id_o.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic gnt_id_o
);

  // On a tie the requester that did not win last time is favoured.
  assign gnt0_o   = valid0_i & (~valid1_i | last_grant_i);
  assign gnt1_o   = valid1_i & (~valid0_i | ~last_grant_i);
  assign gnt_id_o = gnt1_o;

endmodule

// File: rtl/tx_block_scheduler.sv
// Arbitrates two block sources onto one byte-serial UART TX stream.
// Ports: clk/rst, reqN_valid_i/reqN_data_i/reqN_ready_o, byte_valid_o/
// byte_data_o/byte_ready_i, busy_o, grant_id_o.
module tx_block_scheduler
  import tx_sched_pkg::*;
#(
  parameter int         NUM_BYTES = NUM_BYTES_DEF,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR0      = HDR0_DEF,
  parameter logic [7:0] HDR1      = HDR1_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid_i,
  input  logic [8*NUM_BYTES-1:0] req0_data_i,
  output logic                   req0_ready_o,
  input  logic                   req1_valid_i,
  input  logic [8*NUM_BYTES-1:0] req1_data_i,
  output logic                   req1_ready_o,
  output logic                   byte_valid_o,
  output logic [7:0]             byte_data_o,
  input  logic                   byte_ready_i,
  output logic                   busy_o,
  output logic                   grant_id_o
);

  localparam int BW = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   shadow_q, shadow_d;
  logic            bv_q, bv_d;
  logic [7:0]      bd_q, bd_d;
  logic            gid_q, gid_d;
  logic            last_q, last_d;

  logic            gnt0, gnt1, gnt_id;
  logic            idle, accept, xfer;
  logic [BW-1:0]   win_data;

  function automatic logic [7:0] byte_sel(
    input logic [BW-1:0] blk,
    input logic [CW-1:0] idx
  );
    logic [BW-1:0] sh;
    sh = blk >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  rr_arb2 u_arb (
    .valid0_i     (req0_valid_i),
    .valid1_i     (req1_valid_i),
    .last_grant_i (last_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1),
    .gnt_id_o     (gnt_id)
  );

  assign idle     = (state_q == S_IDLE);
  assign accept   = idle & (gnt0 | gnt1) & ~rst;
  assign xfer     = bv_q & byte_ready_i;
  assign win_data = gnt1 ? req1_data_i : req0_data_i;

  // Ready is gated by rst so nothing is accepted while held in reset.
  assign req0_ready_o = idle & gnt0 & ~rst;
  assign req1_ready_o = idle & gnt1 & ~rst;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bv_d     = bv_q;
    bd_d     = bd_q;
    gid_d    = gid_q;
    last_d   = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shadow_d = win_data;
          gid_d    = gnt_id;
          last_d   = gnt_id;
          cnt_d    = '0;
          bv_d     = 1'b1;
          if (HDR_EN) begin
            state_d = S_HDR;
            bd_d    = gnt_id ? HDR1 : HDR0;
          end else begin
            // Shadow is not loaded yet, so take byte 0 from the winner.
            state_d = S_SEND;
            bd_d    = win_data[7:0];
          end
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d = S_SEND;
          bd_d    = shadow_q[7:0];
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (cnt_q == LAST) begin
            state_d = S_GAP;
            bv_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            bd_d  = byte_sel(shadow_q, cnt_q + CW'(1));
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      bv_q     <= 1'b0;
      bd_q     <= 8'h00;
      gid_q    <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bv_q     <= bv_d;
      bd_q     <= bd_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
    end
  end

  assign byte_valid_o = bv_q;
  assign byte_data_o  = bd_q;
  assign grant_id_o   = gid_q;
  assign busy_o       = ~idle;

endmodule

// File: tb/tb_tx_block_scheduler.sv
// Directed self-checking bench for tx_block_scheduler.
// Drives at negedge, checks at negedge, one header and one no-header DUT.
module tb_tx_block_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        byte_valid, byte_ready, busy, grant_id;
  logic [7:0]  byte_data;

  logic        nh_req0_valid, nh_req1_valid;
  logic [63:0] nh_req0_data, nh_req1_data;
  logic        nh_req0_ready, nh_req1_ready;
  logic        nh_byte_valid, nh_byte_ready, nh_busy, nh_grant_id;
  logic [7:0]  nh_byte_data;

  int passed = 0;
  int total  = 0;
  int acc0 = 0, acc1 = 0, both = 0, nh_xfers = 0;

  localparam logic [63:0] D0 = 64'h0706050403020100;
  localparam logic [63:0] D1 = 64'hFFEEDDCCBBAA9988;
  localparam logic [63:0] D2 = 64'h8877665544332211;
  localparam logic [63:0] D3 = 64'h0123456789ABCDEF;

  tx_block_scheduler #(.HDR_EN(1'b1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .byte_ready_i (byte_ready),
    .busy_o       (busy),
    .grant_id_o   (grant_id)
  );

  tx_block_scheduler #(.HDR_EN(1'b0)) u_nh (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (nh_req0_valid),
    .req0_data_i  (nh_req0_data),
    .req0_ready_o (nh_req0_ready),
    .req1_valid_i (nh_req1_valid),
    .req1_data_i  (nh_req1_data),
    .req1_ready_o (nh_req1_ready),
    .byte_valid_o (nh_byte_valid),
    .byte_data_o  (nh_byte_data),
    .byte_ready_i (nh_byte_ready),
    .busy_o       (nh_busy),
    .grant_id_o   (nh_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req0_ready) acc0++;
    if (req1_ready) acc1++;
    if (req0_ready && req1_ready) both++;
    if (nh_byte_valid && nh_byte_ready) nh_xfers++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called on the negedge right after the accept edge. Walks the
  // byte stream, optionally stalling at sequence index stall_at,
  // then checks the GAP cycle and the return to idle.
  task automatic xblk(input string tag, input bit nh,
                      input logic [7:0] hdr, input logic [63:0] blk,
                      input logic gid, input int stall_at,
                      input int stall_len);
    int n;
    int p;
    logic [7:0] e;
    n = nh ? 8 : 9;
    chk({tag, "_gid"}, nh ? nh_grant_id : grant_id, gid);
    for (int k = 0; k < n; k++) begin
      p = nh ? k : k - 1;
      if (p < 0) e = hdr;
      else e = 8'(blk >> (8 * p));
      chk($sformatf("%s_v%0d", tag, k), nh ? nh_byte_valid : byte_valid, 1);
      chk($sformatf("%s_d%0d", tag, k), nh ? nh_byte_data : byte_data, e);
      chk($sformatf("%s_busy%0d", tag, k), nh ? nh_busy : busy, 1);
      if (k == stall_at) begin
        if (nh) nh_byte_ready = 1'b0;
        else byte_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk($sformatf("%s_sv%0d", tag, s),
              nh ? nh_byte_valid : byte_valid, 1);
          chk($sformatf("%s_sd%0d", tag, s),
              nh ? nh_byte_data : byte_data, e);
        end
        if (nh) nh_byte_ready = 1'b1;
        else byte_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({tag, "_gap_v"}, nh ? nh_byte_valid : byte_valid, 0);
    chk({tag, "_gap_busy"}, nh ? nh_busy : busy, 1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, nh ? nh_busy : busy, 0);
  endtask

  int a0, a1, b0, x0;

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    byte_ready = 1'b1;
    nh_req0_valid = 0; nh_req1_valid = 0;
    nh_req0_data = '0; nh_req1_data = '0;
    nh_byte_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_bv", byte_valid, 0);
    chk("rst_nh_bv", nh_byte_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bv2", byte_valid, 0);
    chk("rst_bd", byte_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);

    // 1: single request
    req0_valid = 1'b1;
    req0_data  = D0;
    #1;
    chk("t1_r0", req0_ready, 1);
    chk("t1_r1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    xblk("t1", 0, 8'hA5, D0, 0, -1, 0);

    // 2: simultaneous requests from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a0 = acc0; a1 = acc1; b0 = both;
    req0_valid = 1'b1; req0_data = D0;
    req1_valid = 1'b1; req1_data = D1;
    #1;
    chk("t2_r0a", req0_ready, 1);
    chk("t2_r1a", req1_ready, 0);
    @(negedge clk);
    xblk("t2a", 0, 8'hA5, D0, 0, -1, 0);
    chk("t2_r0b", req0_ready, 0);
    chk("t2_r1b", req1_ready, 1);
    @(negedge clk);
    xblk("t2b", 0, 8'h5A, D1, 1, -1, 0);
    chk("t2_r0c", req0_ready, 1);
    chk("t2_r1c", req1_ready, 0);
    @(negedge clk);
    xblk("t2c", 0, 8'hA5, D0, 0, -1, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t2_acc0", acc0 - a0, 2);
    chk("t2_acc1", acc1 - a1, 1);
    chk("t2_both", both - b0, 0);

    // 3: backpressure while byte 03 is presented
    @(negedge clk);
    req0_valid = 1'b1; req0_data = D0;
    #1;
    chk("t3_r0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    xblk("t3", 0, 8'hA5, D0, 0, 4, 5);

    // 4: header disabled
    x0 = nh_xfers;
    nh_req0_valid = 1'b1; nh_req0_data = D2;
    #1;
    chk("t4_r0", nh_req0_ready, 1);
    @(negedge clk);
    nh_req0_valid = 1'b0;
    xblk("t4", 1, 8'h00, D2, 0, -1, 0);
    chk("t4_xfers", nh_xfers - x0, 8);

    // 5: reset after byte 04 has been accepted
    @(negedge clk);
    req0_valid = 1'b1; req0_data = D0;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_pre_v", byte_valid, 1);
    chk("t5_pre_d", byte_data, 8'h05);
    rst = 1'b1;
    #1;
    chk("t5_rst_v", byte_valid, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = D0;
    req1_valid = 1'b1; req1_data = D1;
    #1;
    chk("t5_r0", req0_ready, 1);
    chk("t5_r1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    xblk("t5", 0, 8'hA5, D0, 0, -1, 0);

    // 6: source data changes right after accept
    req0_valid = 1'b1; req0_data = D3;
    #1;
    chk("t6_r0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req0_data  = 64'hDEADBEEFCAFEF00D;
    xblk("t6", 0, 8'hA5, D3, 0, -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
